// File: rtl/lcd_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | lcd_pkg : shared LCD command encodings, store geometry, host FSM states   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
package lcd_pkg;

  localparam int IMG_DEPTH = 64;
  localparam int ADDR_W    = 6;
  localparam int DATA_W    = 8;
  localparam int CMD_W     = 4;
  localparam int COUNT_W   = 7;

  typedef enum logic [CMD_W-1:0] {
    CMD_WRITE = 4'd0,
    CMD_UP    = 4'd1,
    CMD_DOWN  = 4'd2,
    CMD_LEFT  = 4'd3,
    CMD_RIGHT = 4'd4,
    CMD_MAX   = 4'd5,
    CMD_MIN   = 4'd6,
    CMD_AVG   = 4'd7,
    CMD_CCW   = 4'd8,
    CMD_CW    = 4'd9,
    CMD_MIRX  = 4'd10,
    CMD_MIRY  = 4'd11
  } lcd_cmd_e;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_BUSY = 3'd1,
    ST_HOLD      = 3'd2,
    ST_DRAIN     = 3'd3,
    ST_DONE      = 3'd4
  } host_state_e;

endpackage : lcd_pkg
`default_nettype wire

// File: rtl/lcd_host_ctrl_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | lcd_host_ctrl_if : controller-facing cmd / IROM / IRAM bundle            |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
interface lcd_host_ctrl_if;
  import lcd_pkg::*;

  logic [CMD_W-1:0]  cmd;
  logic              cmd_valid;
  logic              busy;
  logic              IROM_rd;
  logic [ADDR_W-1:0] IROM_A;
  logic [DATA_W-1:0] IROM_Q;
  logic              IRAM_valid;
  logic [ADDR_W-1:0] IRAM_A;
  logic [DATA_W-1:0] IRAM_D;
  logic              done;

  // Host side: issues commands and serves the image ROM.
  modport master (
    output cmd, cmd_valid, IROM_Q,
    input  busy, IROM_rd, IROM_A, IRAM_valid, IRAM_A, IRAM_D, done
  );

  // Controller side.
  modport slave (
    input  cmd, cmd_valid, IROM_Q,
    output busy, IROM_rd, IROM_A, IRAM_valid, IRAM_A, IRAM_D, done
  );

endinterface : lcd_host_ctrl_if
`default_nettype wire

// File: rtl/lcd_cmd_fifo.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | lcd_cmd_fifo : synchronous FIFO, first-word-fall-through head            |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module lcd_cmd_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
  logic             do_push;
  logic             do_pop;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                 (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign rdata = mem[rd_ptr_q[PTR_W-1:0]];

  always_comb begin
    do_push  = push && !full;
    do_pop   = pop && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) begin
      wr_ptr_d = wr_ptr_q + {{PTR_W{1'b0}}, 1'b1};
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + {{PTR_W{1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_q[PTR_W-1:0]] <= wdata;
    end
  end

endmodule : lcd_cmd_fifo
`default_nettype wire

// File: rtl/lcd_host_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | lcd_host_ctrl : image ROM server, command issuer, write-back capture     |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module lcd_host_ctrl
  import lcd_pkg::*;
#(
  parameter int CMD_DEPTH = 16,
  parameter int CKSUM_W   = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                img_wr_en,
  input  logic [ADDR_W-1:0]   img_wr_addr,
  input  logic [DATA_W-1:0]   img_wr_data,
  input  logic [CMD_W-1:0]    cmd_in,
  input  logic                cmd_in_valid,
  output logic                cmd_in_ready,
  input  logic                start,
  lcd_host_ctrl_if.master     ctrl,
  input  logic [ADDR_W-1:0]   res_rd_addr,
  output logic [DATA_W-1:0]   res_rd_data,
  output logic [COUNT_W-1:0]  res_count,
  output logic [CKSUM_W-1:0]  res_checksum,
  output logic                host_done,
  output logic                err_overflow,
  output logic                err_protocol
);

  localparam logic [COUNT_W-1:0] COUNT_MAX = COUNT_W'(IMG_DEPTH);

  host_state_e          state_q, state_d;
  logic [CMD_W-1:0]     cmd_q, cmd_d;
  logic                 cmd_valid_q, cmd_valid_d;
  logic [COUNT_W-1:0]   count_q, count_d;
  logic [CKSUM_W-1:0]   cksum_q, cksum_d;
  logic                 host_done_q, host_done_d;
  logic                 err_ovf_q, err_ovf_d;
  logic                 err_prot_q, err_prot_d;

  logic                 fifo_pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [CMD_W-1:0]     fifo_head;
  logic                 session_clr;
  logic                 capture_en;

  logic [DATA_W-1:0]    img_mem [IMG_DEPTH];
  logic [DATA_W-1:0]    res_mem [IMG_DEPTH];

  lcd_cmd_fifo #(
    .DEPTH (CMD_DEPTH),
    .WIDTH (CMD_W)
  ) u_cmd_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (cmd_in_valid),
    .wdata (cmd_in),
    .pop   (fifo_pop),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Image store: the controller samples Q in the same cycle it drives A.
  always_ff @(posedge clk) begin
    if (img_wr_en) begin
      img_mem[img_wr_addr] <= img_wr_data;
    end
  end

  assign ctrl.IROM_Q = (ctrl.IROM_rd && !reset) ? img_mem[ctrl.IROM_A] : '0;

  always_ff @(posedge clk) begin
    if (capture_en) begin
      res_mem[ctrl.IRAM_A] <= ctrl.IRAM_D;
    end
  end

  assign res_rd_data    = res_mem[res_rd_addr];
  assign cmd_in_ready   = !fifo_full;
  assign ctrl.cmd       = cmd_q;
  assign ctrl.cmd_valid = cmd_valid_q;
  assign res_count      = count_q;
  assign res_checksum   = cksum_q;
  assign host_done      = host_done_q;
  assign err_overflow   = err_ovf_q;
  assign err_protocol   = err_prot_q;
  assign capture_en     = ctrl.IRAM_valid && (state_q != ST_IDLE);

  always_comb begin
    state_d     = state_q;
    cmd_d       = cmd_q;
    cmd_valid_d = cmd_valid_q;
    count_d     = count_q;
    cksum_d     = cksum_q;
    host_done_d = host_done_q;
    err_ovf_d   = err_ovf_q;
    err_prot_d  = err_prot_q;
    fifo_pop    = 1'b0;
    session_clr = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          session_clr = 1'b1;
          state_d     = ST_WAIT_BUSY;
        end
      end
      ST_WAIT_BUSY: begin
        if (!ctrl.busy && !fifo_empty) begin
          cmd_d       = fifo_head;
          cmd_valid_d = 1'b1;
          fifo_pop    = 1'b1;
          state_d     = ST_HOLD;
        end
      end
      // One dead cycle keeps cmd_valid to a single pulse per busy-low window.
      ST_HOLD: begin
        cmd_valid_d = 1'b0;
        state_d     = (cmd_q == CMD_WRITE) ? ST_DRAIN : ST_WAIT_BUSY;
      end
      ST_DRAIN: begin
        if (ctrl.done) begin
          host_done_d = 1'b1;
          state_d     = ST_DONE;
        end
      end
      ST_DONE: begin
        if (start) begin
          session_clr = 1'b1;
          state_d     = ST_WAIT_BUSY;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (session_clr) begin
      count_d     = '0;
      cksum_d     = '0;
      host_done_d = 1'b0;
      err_ovf_d   = 1'b0;
      err_prot_d  = 1'b0;
    end

    if (capture_en) begin
      count_d = (count_d == COUNT_MAX) ? COUNT_MAX : count_d + COUNT_W'(1);
      cksum_d = cksum_d + CKSUM_W'(ctrl.IRAM_D);
    end

    if (cmd_in_valid && fifo_full) begin
      err_ovf_d = 1'b1;
    end

    if ((ctrl.IRAM_valid || ctrl.done) && (state_q != ST_DRAIN)) begin
      err_prot_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cmd_q       <= '0;
      cmd_valid_q <= 1'b0;
      count_q     <= '0;
      cksum_q     <= '0;
      host_done_q <= 1'b0;
      err_ovf_q   <= 1'b0;
      err_prot_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_q       <= cmd_d;
      cmd_valid_q <= cmd_valid_d;
      count_q     <= count_d;
      cksum_q     <= cksum_d;
      host_done_q <= host_done_d;
      err_ovf_q   <= err_ovf_d;
      err_prot_q  <= err_prot_d;
    end
  end

endmodule : lcd_host_ctrl
`default_nettype wire

// File: tb/tb_lcd_host_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_lcd_host_ctrl : scoreboard bench for the LCD host controller          |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`timescale 1ns/1ps
module tb_lcd_host_ctrl;
  import lcd_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        img_wr_en = 1'b0;
  logic [5:0]  img_wr_addr = '0;
  logic [7:0]  img_wr_data = '0;
  logic [3:0]  cmd_in = '0;
  logic        cmd_in_valid = 1'b0;
  logic        cmd_in_ready;
  logic        start = 1'b0;
  logic [5:0]  res_rd_addr = '0;
  logic [7:0]  res_rd_data;
  logic [6:0]  res_count;
  logic [15:0] res_checksum;
  logic        host_done;
  logic        err_overflow;
  logic        err_protocol;

  logic        busy_man = 1'b1;
  logic        busy_auto = 1'b0;
  logic        auto_busy = 1'b0;

  int          checks = 0;
  int          errors = 0;
  int          issued = 0;
  int          snap;
  logic [3:0]  exp_q [$];
  logic [3:0]  exp_cmd;
  logic        prev_valid = 1'b0;

  lcd_host_ctrl_if bus ();

  assign bus.busy = auto_busy ? busy_auto : busy_man;

  lcd_host_ctrl #(.CMD_DEPTH(16), .CKSUM_W(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .img_wr_en    (img_wr_en),
    .img_wr_addr  (img_wr_addr),
    .img_wr_data  (img_wr_data),
    .cmd_in       (cmd_in),
    .cmd_in_valid (cmd_in_valid),
    .cmd_in_ready (cmd_in_ready),
    .start        (start),
    .ctrl         (bus),
    .res_rd_addr  (res_rd_addr),
    .res_rd_data  (res_rd_data),
    .res_count    (res_count),
    .res_checksum (res_checksum),
    .host_done    (host_done),
    .err_overflow (err_overflow),
    .err_protocol (err_protocol)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every issued command is popped from the scoreboard and compared.
  always @(negedge clk) begin
    if (bus.cmd_valid === 1'b1) begin
      issued++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL cmd_unexpected: got cmd %0d expected no issue", bus.cmd);
      end else begin
        exp_cmd = exp_q.pop_front();
        if (bus.cmd !== exp_cmd) begin
          errors++;
          $display("FAIL cmd_value: got %0d expected %0d", bus.cmd, exp_cmd);
        end
      end
      checks++;
      if (prev_valid !== 1'b0) begin
        errors++;
        $display("FAIL cmd_valid_b2b: got back-to-back cmd_valid expected single pulse");
      end
    end
    prev_valid = bus.cmd_valid;
  end

  // Simple controller model: busy for two cycles after each command.
  initial begin
    forever begin
      @(negedge clk);
      if (auto_busy && bus.cmd_valid === 1'b1) begin
        busy_auto = 1'b1;
        repeat (2) @(negedge clk);
        busy_auto = 1'b0;
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic push_cmd(input logic [3:0] c, input bit accepted);
    @(negedge clk);
    cmd_in = c;
    cmd_in_valid = 1'b1;
    if (accepted) exp_q.push_back(c);
    @(negedge clk);
    cmd_in_valid = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic busy_window(input string name);
    @(negedge clk);
    busy_man = 1'b0;
    @(negedge clk);
    busy_man = 1'b1;
    #1 check({name, "_valid_hi"}, 32'(bus.cmd_valid), 32'd1);
    @(negedge clk);
    #1 check({name, "_valid_lo"}, 32'(bus.cmd_valid), 32'd0);
  endtask

  task automatic pulse_done();
    @(negedge clk);
    bus.done = 1'b1;
    @(negedge clk);
    bus.done = 1'b0;
  endtask

  initial begin
    bus.IROM_rd = 1'b0;
    bus.IROM_A = '0;
    bus.IRAM_valid = 1'b0;
    bus.IRAM_A = '0;
    bus.IRAM_D = '0;
    bus.done = 1'b0;

    // Reset values
    repeat (2) @(negedge clk);
    reset = 1'b0;
    #1;
    check("rst_cmd", 32'(bus.cmd), 32'd0);
    check("rst_cmd_valid", 32'(bus.cmd_valid), 32'd0);
    check("rst_irom_q", 32'(bus.IROM_Q), 32'd0);
    check("rst_count", 32'(res_count), 32'd0);
    check("rst_cksum", 32'(res_checksum), 32'd0);
    check("rst_host_done", 32'(host_done), 32'd0);
    check("rst_err_ovf", 32'(err_overflow), 32'd0);
    check("rst_err_prot", 32'(err_protocol), 32'd0);
    check("rst_ready", 32'(cmd_in_ready), 32'd1);

    // Image ROM: img[i] = i, zero-latency read
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      img_wr_en = 1'b1;
      img_wr_addr = 6'(i);
      img_wr_data = 8'(i);
    end
    @(negedge clk);
    img_wr_en = 1'b0;
    pulse_start();
    for (int a = 0; a < 64; a++) begin
      @(negedge clk);
      bus.IROM_rd = 1'b1;
      bus.IROM_A = 6'(a);
      #1 check("irom_sweep", 32'(bus.IROM_Q), 32'(a));
    end
    @(negedge clk);
    bus.IROM_rd = 1'b0;
    #1 check("irom_rd_low", 32'(bus.IROM_Q), 32'd0);
    @(negedge clk);
    bus.IROM_rd = 1'b1;
    bus.IROM_A = 6'd5;
    img_wr_en = 1'b1;
    img_wr_addr = 6'd5;
    img_wr_data = 8'hAA;
    #1 check("irom_same_cycle_old", 32'(bus.IROM_Q), 32'd5);
    @(negedge clk);
    img_wr_data = 8'd5;
    #1 check("irom_next_cycle_new", 32'(bus.IROM_Q), 32'hAA);
    @(negedge clk);
    img_wr_en = 1'b0;
    bus.IROM_rd = 1'b0;

    // Command issue {4,7,0} then write-back drain
    do_reset();
    busy_man = 1'b1;
    push_cmd(4'd4, 1'b1);
    push_cmd(4'd7, 1'b1);
    push_cmd(4'd0, 1'b1);
    pulse_start();
    repeat (3) @(negedge clk);
    busy_window("issue_4");
    snap = issued;
    repeat (5) @(negedge clk);
    #1 check("no_issue_while_busy", 32'(issued), 32'(snap));
    busy_window("issue_7");
    busy_window("issue_0");
    for (int a = 0; a < 64; a++) begin
      @(negedge clk);
      bus.IRAM_valid = 1'b1;
      bus.IRAM_A = 6'(a);
      bus.IRAM_D = 8'(a + 1);
    end
    @(negedge clk);
    bus.IRAM_valid = 1'b0;
    pulse_done();
    res_rd_addr = 6'd10;
    #1;
    check("drain_count", 32'(res_count), 32'd64);
    check("drain_cksum", 32'(res_checksum), 32'd2080);
    check("drain_rd_10", 32'(res_rd_data), 32'd11);
    check("drain_host_done", 32'(host_done), 32'd1);
    check("drain_err_prot", 32'(err_protocol), 32'd0);

    // FIFO overflow: 17 pushes, 16 accepted and issued
    do_reset();
    busy_man = 1'b1;
    for (int i = 0; i < 16; i++) push_cmd(4'((i % 15) + 1), 1'b1);
    #1 check("full_ready_low", 32'(cmd_in_ready), 32'd0);
    push_cmd(4'd9, 1'b0);
    #1 check("overflow_flag", 32'(err_overflow), 32'd1);
    snap = issued;
    auto_busy = 1'b1;
    busy_auto = 1'b0;
    pulse_start();
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clk);
    #1 check("issue_drain_timeout", 32'(exp_q.size()), 32'd0);
    repeat (10) @(negedge clk);
    #1 check("issued_16", 32'(issued - snap), 32'd16);
    check("ready_after_drain", 32'(cmd_in_ready), 32'd1);
    auto_busy = 1'b0;

    // Protocol errors in WAIT_BUSY
    do_reset();
    busy_man = 1'b1;
    pulse_start();
    @(negedge clk);
    bus.IRAM_valid = 1'b1;
    bus.IRAM_A = 6'd3;
    bus.IRAM_D = 8'h55;
    @(negedge clk);
    bus.IRAM_valid = 1'b0;
    res_rd_addr = 6'd3;
    #1;
    check("prot_err_iram", 32'(err_protocol), 32'd1);
    check("prot_count", 32'(res_count), 32'd1);
    check("prot_cksum", 32'(res_checksum), 32'h55);
    check("prot_captured", 32'(res_rd_data), 32'h55);
    pulse_done();
    #1 check("prot_done_ignored", 32'(host_done), 32'd0);

    // Reset in the middle of DRAIN
    do_reset();
    busy_man = 1'b1;
    push_cmd(4'd0, 1'b1);
    pulse_start();
    busy_window("issue_wr");
    for (int a = 0; a < 20; a++) begin
      @(negedge clk);
      bus.IRAM_valid = 1'b1;
      bus.IRAM_A = 6'(a);
      bus.IRAM_D = 8'(8'h10 + a);
    end
    @(negedge clk);
    bus.IRAM_valid = 1'b0;
    #1;
    check("mid_count", 32'(res_count), 32'd20);
    check("mid_cksum", 32'(res_checksum), 32'd510);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("abort_count", 32'(res_count), 32'd0);
    check("abort_cksum", 32'(res_checksum), 32'd0);
    check("abort_cmd", 32'(bus.cmd), 32'd0);
    check("abort_valid", 32'(bus.cmd_valid), 32'd0);
    check("abort_host_done", 32'(host_done), 32'd0);
    check("abort_err_ovf", 32'(err_overflow), 32'd0);
    check("abort_err_prot", 32'(err_protocol), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    bus.IROM_rd = 1'b1;
    bus.IROM_A = 6'd9;
    #1;
    check("abort_ready", 32'(cmd_in_ready), 32'd1);
    check("image_survives", 32'(bus.IROM_Q), 32'd9);
    bus.IROM_rd = 1'b0;
    snap = issued;
    busy_man = 1'b0;
    pulse_start();
    repeat (8) @(negedge clk);
    #1 check("fifo_empty_after_abort", 32'(issued), 32'(snap));
    busy_man = 1'b1;

    check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_lcd_host_ctrl
`default_nettype wire

// File: doc/lcd_host_ctrl.md
Name: lcd_host_ctrl

Overview:
- Host-side counterpart of the LCD controller. It sits between the system/test harness and the controller's cmd/IROM/IRAM interfaces.
- It serves the image ROM (IROM_rd/IROM_A → IROM_Q) from an internal 64x8 image store, and queues commands from upstream.
- It issues queued commands on the cmd/cmd_valid/busy handshake.
- It captures the controller's IRAM write-back stream into a 64x8 result store with count and checksum, and reports completion on done.

Parameters:
- CMD_DEPTH, 16, command FIFO entries (power of 2, ≥2).
- CKSUM_W, 16, result checksum width.

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- img_wr_en  in  1  image store write strobe
- img_wr_addr  in  6  image store write address
- img_wr_data  in  8  image store write data
- cmd_in  in  4  upstream command
- cmd_in_valid  in  1  upstream command push
- cmd_in_ready  out  1  FIFO not full
- start  in  1  one-cycle pulse, begin a session
- cmd  out  4  command to controller
- cmd_valid  out  1  command strobe to controller
- busy  in  1  controller busy
- IROM_rd  in  1  controller ROM read enable
- IROM_A  in  6  controller ROM address
- IROM_Q  out  8  ROM data
- IRAM_valid  in  1  controller write-back strobe
- IRAM_A  in  6  write-back address
- IRAM_D  in  8  write-back data
- done  in  1  controller done
- res_rd_addr  in  6  result store read address
- res_rd_data  out  8  result store data (combinational)
- res_count  out  7  accepted IRAM writes this session
- res_checksum  out  CKSUM_W  wrapping sum of IRAM_D this session
- host_done  out  1  session complete (sticky)
- err_overflow  out  1  push attempted while FIFO full (sticky)
- err_protocol  out  1  IRAM_valid or done outside DRAIN (sticky)

Behaviour:
- Reset values:
  - cmd=0, cmd_valid=0, IROM_Q=0, res_count=0, res_checksum=0, host_done=0, err_overflow=0, err_protocol=0.
  - FIFO empty (cmd_in_ready=1), state IDLE.
  - Image/result stores are not reset.
- Reset mid-session aborts immediately to the values above. Image contents survive.
- IROM_Q is combinational: img[IROM_A] when IROM_rd=1, else 0. This is zero-latency, because the controller samples Q in the same cycle it drives IROM_A.
- If img_wr_en hits the same address in that cycle, IROM_Q returns the old value; the new value is visible next cycle.
- Command FIFO (CMD_DEPTH x 4):
  - A push occurs when cmd_in_valid & cmd_in_ready; pops occur only in WAIT_BUSY issue.
  - cmd_in_valid while full: data dropped, err_overflow<=1.
  - A push and a pop in the same cycle are both honoured.
- FSM states: IDLE, WAIT_BUSY, HOLD, DRAIN, DONE.
  - IDLE: on start → WAIT_BUSY. Clear res_count, res_checksum, host_done, err_overflow, err_protocol. FIFO contents are kept.
  - WAIT_BUSY: if busy=0 and FIFO non-empty, then cmd<=head, cmd_valid<=1, pop, → HOLD. Otherwise stay; with an empty FIFO it waits indefinitely.
  - HOLD (1 cycle): cmd_valid<=0. If the issued cmd==0 (write-back), → DRAIN; else → WAIT_BUSY. HOLD guarantees at most one command per busy-low window and never a back-to-back cmd_valid.
  - DRAIN: no further pops. Capture IRAM writes. On done=1, host_done<=1 → DONE.
  - DONE: host_done held. start → IDLE-equivalent clear, then → WAIT_BUSY.
- Start received in WAIT_BUSY/HOLD/DRAIN is ignored.
- cmd_valid is registered: it rises one cycle after the busy=0 sample and stays high exactly 1 cycle. cmd holds its value until the next issue.
- Capture, every cycle IRAM_valid=1:
  - res[IRAM_A]<=IRAM_D.
  - res_checksum<=res_checksum+IRAM_D, zero-extended, wraps mod 2^CKSUM_W.
  - res_count increments and saturates at 64.
  - Capture is active in any state except IDLE. An IRAM_valid outside DRAIN also sets err_protocol.
- done=1 outside DRAIN sets err_protocol and does not set host_done.
- res_rd_data = res[res_rd_addr] combinationally. A same-cycle capture write to that address shows the old value.

Decomposition:
- Shared package lcd_pkg:
  - LCD command encodings: WRITE=0, UP=1, DOWN=2, LEFT=3, RIGHT=4, MAX=5, MIN=6, AVG=7, CCW=8, CW=9, MIRX=10, MIRY=11.
  - IMG_DEPTH=64, ADDR_W=6, DATA_W=8.
  - Host state enum.
- One sub-module, lcd_cmd_fifo (sync FIFO, parameterised depth/width, full/empty flags, push/pop).
- Stores and FSM stay in the top.

Test Plan:
- Load image img[i]=i; start; IROM_rd=1 sweeping IROM_A 0..63 → IROM_Q equals IROM_A every cycle; IROM_rd=0 → IROM_Q=0.
- Push {4,7,0}; start; busy low one cycle at t → cmd_valid high at t+1 with cmd=4, then low. The next command is issued only after busy is high then low again. cmd=0 is issued last → state DRAIN.
- In DRAIN, drive IRAM_valid with A=0..63, D=A+1, then done → res_count=64, res_checksum=2080, res_rd_data at addr 10 = 11, host_done=1.
- Push 17 commands with CMD_DEPTH=16 while idle → cmd_in_ready=0 after 16 pushes, err_overflow=1, and exactly 16 commands are issued later.
- IRAM_valid pulse while in WAIT_BUSY → err_protocol=1, result still captured; done in WAIT_BUSY → host_done stays 0.
- Assert reset during DRAIN after 20 captures → all outputs back to reset values, FIFO empty; the image store still returns the prior data.
